// File: rtl/vga_pkg.sv
// Purpose : shared 640x480@60 VGA timing constants and small decode helpers.
// Contents: default porch/sync widths, derived totals, sync window bounds, counter type.
// Latency/backpressure: n/a (constants only); pixel generators should use these, not literals.
package vga_pkg;

  localparam int CNT_W = 11;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam int CLK_DIV  = 2;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Half-open window test used by the sync decoders: lo <= x < hi.
  function automatic logic in_window(cnt_t x, cnt_t lo, cnt_t hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Purpose : raster timing bundle driven by vga_timing_gen, consumed by pixel generators.
// Ports   : pix_en strobe, hcount/vcount position, blank, hsync/vsync (active low), frame_start.
// Latency/backpressure: all fields registered at the source; no backpressure, consumers just sample.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic pix_en;
  cnt_t hcount;
  cnt_t vcount;
  logic blank;
  logic hsync;
  logic vsync;
  logic frame_start;

  modport master (output pix_en, hcount, vcount, blank, hsync, vsync, frame_start);
  modport slave  (input  pix_en, hcount, vcount, blank, hsync, vsync, frame_start);

endinterface

// File: rtl/pix_clk_en.sv
// Purpose : pixel-rate clock enable, one clk high every CLK_DIV board clocks.
// Ports   : clk, rst_n (async active low) in; pix_en out (registered).
// Latency/backpressure: first strobe CLK_DIV clks after reset release; free-running, no backpressure.
module pix_clk_en #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_en
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;

  // With CLK_DIV = 1 the divider sits at 0 == DIV_LAST, so pix_en stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div    <= '0;
      pix_en <= 1'b0;
    end else begin
      pix_en <= (div == DIV_LAST);
      div    <= (div == DIV_LAST) ? '0 : div + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose : VGA raster timing generator (hcount/vcount, blank, hsync/vsync, frame_start) on one clock.
// Ports   : clk, rst_n (async active low); vga (vga_timing_gen_if.master) carries all outputs.
// Latency/backpressure: decode registered on the same edge as the counters (zero skew); no backpressure.
module vga_timing_gen #(
  parameter int CLK_DIV  = vga_pkg::CLK_DIV,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_timing_gen_if.master vga
);

  localparam vga_pkg::cnt_t H_LAST   = vga_pkg::cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam vga_pkg::cnt_t V_LAST   = vga_pkg::cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam vga_pkg::cnt_t H_ACT    = vga_pkg::cnt_t'(H_ACTIVE);
  localparam vga_pkg::cnt_t V_ACT    = vga_pkg::cnt_t'(V_ACTIVE);
  localparam vga_pkg::cnt_t HS_START = vga_pkg::cnt_t'(H_ACTIVE + H_FP);
  localparam vga_pkg::cnt_t HS_END   = vga_pkg::cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam vga_pkg::cnt_t VS_START = vga_pkg::cnt_t'(V_ACTIVE + V_FP);
  localparam vga_pkg::cnt_t VS_END   = vga_pkg::cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  logic          pix_en;
  vga_pkg::cnt_t hcnt, vcnt;
  vga_pkg::cnt_t h_nxt, v_nxt;
  logic          wrap_frame;
  logic          blank_q, hsync_q, vsync_q, fstart_q;

  pix_clk_en #(.CLK_DIV(CLK_DIV)) u_pix_clk_en (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_en (pix_en)
  );

  assign wrap_frame = (hcnt == H_LAST) && (vcnt == V_LAST);

  always_comb begin
    h_nxt = hcnt;
    v_nxt = vcnt;
    if (hcnt == H_LAST) begin
      h_nxt = '0;
      v_nxt = (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    end else begin
      h_nxt = hcnt + 1'b1;
    end
  end

  // Decode looks at the post-increment position so the flags land on the
  // same edge as the counters they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt     <= '0;
      vcnt     <= '0;
      blank_q  <= 1'b0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      fstart_q <= 1'b0;
    end else begin
      fstart_q <= pix_en && wrap_frame;
      if (pix_en) begin
        hcnt    <= h_nxt;
        vcnt    <= v_nxt;
        blank_q <= (h_nxt >= H_ACT) || (v_nxt >= V_ACT);
        hsync_q <= !vga_pkg::in_window(h_nxt, HS_START, HS_END);
        vsync_q <= !vga_pkg::in_window(v_nxt, VS_START, VS_END);
      end
    end
  end

  assign vga.pix_en      = pix_en;
  assign vga.hcount      = hcnt;
  assign vga.vcount      = vcnt;
  assign vga.blank       = blank_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.frame_start = fstart_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-parameter instance (CLK_DIV=2) checked against a
// hand-computed vector table over the first line, and a shrunken-raster instance (CLK_DIV=1,
// 15x10 total) checked over whole frames, including mid-frame resets on both.
module tb_vga_timing_gen;

  logic clk     = 1'b0;
  logic rst_d_n = 1'b0;
  logic rst_s_n = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen_if if_d();
  vga_timing_gen_if if_s();

  vga_timing_gen #(.CLK_DIV(2)) u_def (
    .clk   (clk),
    .rst_n (rst_d_n),
    .vga   (if_d)
  );

  // Small raster: H 8+2+3+2 = 15, V 4+2+1+3 = 10.
  // blank: h>=8 or v>=4; hsync low for 10<=h<13; vsync low for v==6.
  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(2), .V_SYNC(1), .V_BP(3)
  ) u_sml (
    .clk   (clk),
    .rst_n (rst_s_n),
    .vga   (if_s)
  );

  typedef struct {
    int   k;     // board-clock edges since reset release
    int   h;
    int   v;
    logic pe;
    logic bl;
    logic hs;
    logic vs;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;
  int   kd = 0;
  int   ks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int k, input int h, input int v,
                     input logic pe, input logic bl, input logic hs, input logic vs);
    vec_t r;
    r.k = k; r.h = h; r.v = v; r.pe = pe; r.bl = bl; r.hs = hs; r.vs = vs;
    tbl.push_back(r);
  endtask

  task automatic chk_rst(input string tag, input logic pe, input logic [10:0] h,
                         input logic [10:0] v, input logic bl, input logic hs,
                         input logic vs, input logic fs);
    chk({tag, " hcount"}, 32'(h), 32'd0);
    chk({tag, " vcount"}, 32'(v), 32'd0);
    chk({tag, " flags pe/bl/hs/vs/fs"}, 32'({pe, bl, hs, vs, fs}), 32'b00110);
  endtask

  task automatic step_d();
    @(posedge clk);
    #1;
    kd++;
  endtask

  task automatic step_s();
    @(posedge clk);
    #1;
    ks++;
  endtask

  task automatic run_table(input string tag);
    int hs_low = 0;
    int pe_cnt = 0;
    int fs_cnt = 0;
    foreach (tbl[i]) begin
      while (kd < tbl[i].k) begin
        step_d();
        if (kd <= 1600) begin
          hs_low += (if_d.hsync == 1'b0) ? 1 : 0;
          pe_cnt += (if_d.pix_en == 1'b1) ? 1 : 0;
        end
        fs_cnt += (if_d.frame_start == 1'b1) ? 1 : 0;
      end
      chk($sformatf("%s k=%0d hcount", tag, tbl[i].k), 32'(if_d.hcount), 32'(tbl[i].h));
      chk($sformatf("%s k=%0d vcount", tag, tbl[i].k), 32'(if_d.vcount), 32'(tbl[i].v));
      chk($sformatf("%s k=%0d pix_en", tag, tbl[i].k), 32'(if_d.pix_en), 32'(tbl[i].pe));
      chk($sformatf("%s k=%0d blank", tag, tbl[i].k), 32'(if_d.blank), 32'(tbl[i].bl));
      chk($sformatf("%s k=%0d hsync", tag, tbl[i].k), 32'(if_d.hsync), 32'(tbl[i].hs));
      chk($sformatf("%s k=%0d vsync", tag, tbl[i].k), 32'(if_d.vsync), 32'(tbl[i].vs));
    end
    chk({tag, " hsync low clks in line 0"}, 32'(hs_low), 32'd192);
    chk({tag, " pix_en strobes in line 0"}, 32'(pe_cnt), 32'd800);
    chk({tag, " frame_start pulses"}, 32'(fs_cnt), 32'd0);
  endtask

  // Closed-form expectation for the small raster: after edge k>=1, n = k-1 pixels elapsed.
  task automatic run_small(input string tag, input int kmax);
    int vs_low = 0;
    int bl_cnt = 0;
    int fs_cnt = 0;
    int fs_first = -1;
    int fs_second = -1;
    int n, h, v;
    logic pe, bl, hs, vs, fs;
    for (int k = 0; k <= kmax; k++) begin
      if (k > 0) step_s();
      if (k == 0) begin
        h = 0; v = 0; pe = 0; bl = 0; hs = 1; vs = 1; fs = 0;
      end else begin
        n  = k - 1;
        h  = n % 15;
        v  = (n / 15) % 10;
        pe = 1'b1;
        bl = (h >= 8) || (v >= 4);
        hs = !((h >= 10) && (h < 13));
        vs = (v != 6);
        fs = (n > 0) && (h == 0) && (v == 0);
      end
      chk($sformatf("%s k=%0d hcount", tag, k), 32'(if_s.hcount), 32'(h));
      chk($sformatf("%s k=%0d vcount", tag, k), 32'(if_s.vcount), 32'(v));
      chk($sformatf("%s k=%0d flags pe/bl/hs/vs/fs", tag, k),
          32'({if_s.pix_en, if_s.blank, if_s.hsync, if_s.vsync, if_s.frame_start}),
          32'({pe, bl, hs, vs, fs}));
      if (k >= 1 && k <= 150) begin
        vs_low += (if_s.vsync == 1'b0) ? 1 : 0;
        bl_cnt += (if_s.blank == 1'b1) ? 1 : 0;
      end
      if (if_s.frame_start == 1'b1) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = k;
        else if (fs_second < 0) fs_second = k;
      end
    end
    chk({tag, " vsync low clks per frame"}, 32'(vs_low), 32'd15);
    chk({tag, " blank clks per frame"}, 32'(bl_cnt), 32'd118);
    chk({tag, " frame_start pulse count"}, 32'(fs_cnt), 32'((kmax - 1) / 150));
    if (kmax >= 151) chk({tag, " first frame_start clk"}, 32'(fs_first), 32'd151);
    if (kmax >= 301) chk({tag, " frame period clks"}, 32'(fs_second - fs_first), 32'd150);
  endtask

  initial begin
    // Default-raster expectations: pix_en high after even edges k>=2,
    // hcount after edge k is (k-1)/2 within line 0.
    add(0,    0,   0, 0, 0, 1, 1);
    add(1,    0,   0, 0, 0, 1, 1);
    add(2,    0,   0, 1, 0, 1, 1);
    add(3,    1,   0, 0, 0, 1, 1);
    add(4,    1,   0, 1, 0, 1, 1);
    add(1279, 639, 0, 0, 0, 1, 1);
    add(1280, 639, 0, 1, 0, 1, 1);
    add(1281, 640, 0, 0, 1, 1, 1);
    add(1311, 655, 0, 0, 1, 1, 1);
    add(1313, 656, 0, 0, 1, 0, 1);
    add(1503, 751, 0, 0, 1, 0, 1);
    add(1505, 752, 0, 0, 1, 1, 1);
    add(1599, 799, 0, 0, 1, 1, 1);
    add(1600, 799, 0, 1, 1, 1, 1);
    add(1601, 0,   1, 0, 0, 1, 1);
    add(1603, 1,   1, 0, 0, 1, 1);

    repeat (3) @(posedge clk);
    #1;
    chk_rst("def in reset", if_d.pix_en, if_d.hcount, if_d.vcount,
            if_d.blank, if_d.hsync, if_d.vsync, if_d.frame_start);

    @(negedge clk);
    rst_d_n = 1'b1;
    kd = 0;
    #1;
    run_table("def run1");

    // Move to (300,1), then reset mid-line away from the clock edge.
    while (kd < 2201) step_d();
    chk("def pre-reset hcount", 32'(if_d.hcount), 32'd300);
    chk("def pre-reset vcount", 32'(if_d.vcount), 32'd1);
    @(negedge clk);
    rst_d_n = 1'b0;
    #1;
    chk_rst("def mid reset", if_d.pix_en, if_d.hcount, if_d.vcount,
            if_d.blank, if_d.hsync, if_d.vsync, if_d.frame_start);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk_rst("def reset held", if_d.pix_en, if_d.hcount, if_d.vcount,
              if_d.blank, if_d.hsync, if_d.vsync, if_d.frame_start);
    end
    @(negedge clk);
    rst_d_n = 1'b1;
    kd = 0;
    #1;
    run_table("def run2");

    // Small raster: two full frames plus a bit, then a reset inside the vsync line.
    @(negedge clk);
    rst_s_n = 1'b1;
    ks = 0;
    #1;
    run_small("sml run1", 311);
    while (ks < 396) step_s();
    chk("sml pre-reset hcount", 32'(if_s.hcount), 32'd5);
    chk("sml pre-reset vcount", 32'(if_s.vcount), 32'd6);
    chk("sml pre-reset vsync", 32'(if_s.vsync), 32'd0);
    @(negedge clk);
    rst_s_n = 1'b0;
    #1;
    chk_rst("sml mid reset", if_s.pix_en, if_s.hcount, if_s.vcount,
            if_s.blank, if_s.hsync, if_s.vsync, if_s.frame_start);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk_rst("sml reset held", if_s.pix_en, if_s.hcount, if_s.vcount,
              if_s.blank, if_s.hsync, if_s.vsync, if_s.frame_start);
    end
    @(negedge clk);
    rst_s_n = 1'b1;
    ks = 0;
    #1;
    run_small("sml run2", 160);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
